// File: rtl/fir_mac_serial.sv
// Serial FIR filter: one time-shared multiplier walks the delay line and
// coefficient bank, one tap per clock, and publishes a saturated result.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for a sample; coefficient writes accepted
// S_MAC  | accumulating d[idx]*c[idx], one tap per cycle
// S_DONE | registering sat(acc) onto y and pulsing y_valid
module fir_mac_serial #(
   parameter int DATA_W = 12,
   parameter int COEF_W = 12,
   parameter int TAPS   = 8,
   parameter int ACC_W  = 32
) (
   input  logic                      clk,
   input  logic                      nreset,
   input  logic                      coef_we,
   input  logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0]  coef_data,
   input  logic                      x_valid,
   output logic                      x_ready,
   input  logic signed [DATA_W-1:0]  x,
   output logic                      y_valid,
   output logic signed [ACC_W-1:0]   y,
   output logic                      busy
);

   localparam int IW = $clog2(TAPS);
   localparam int PW = DATA_W + COEF_W;
   // log2(TAPS) guard bits keep the sum of TAPS full-scale products from wrapping
   localparam int AW = PW + IW;
   localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

   state_t                   state;
   logic [IW-1:0]            idx;
   logic signed [AW-1:0]     acc;
   logic signed [DATA_W-1:0] d [TAPS];
   logic signed [COEF_W-1:0] c [TAPS];
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  sat_y;
   logic                     coef_ok;

   assign prod = PW'(d[idx]) * PW'(c[idx]);

   generate
      if (TAPS == (1 << IW)) begin : g_addr_full
         assign coef_ok = 1'b1;
      end else begin : g_addr_partial
         assign coef_ok = (int'(coef_addr) < TAPS);
      end
   endgenerate

   generate
      if (AW > ACC_W) begin : g_sat
         localparam logic signed [AW-1:0] SAT_MAX = {{(AW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
         localparam logic signed [AW-1:0] SAT_MIN = {{(AW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
         always_comb begin
            sat_y = acc[ACC_W-1:0];
            if (acc > SAT_MAX) begin
               sat_y = {1'b0, {(ACC_W-1){1'b1}}};
            end else if (acc < SAT_MIN) begin
               sat_y = {1'b1, {(ACC_W-1){1'b0}}};
            end
         end
      end else begin : g_ext
         assign sat_y = ACC_W'(acc);
      end
   endgenerate

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state   <= S_IDLE;
         idx     <= '0;
         acc     <= '0;
         y       <= '0;
         y_valid <= 1'b0;
         x_ready <= 1'b0;
         busy    <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            d[k] <= '0;
            c[k] <= '0;
         end
      end else begin
         y_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               // a write on the accept edge lands before the MAC pass reads c
               if (coef_we && coef_ok) begin
                  c[coef_addr] <= coef_data;
               end
               if (x_valid && x_ready) begin
                  d[0] <= x;
                  for (int k = 1; k < TAPS; k++) begin
                     d[k] <= d[k-1];
                  end
                  acc     <= '0;
                  idx     <= '0;
                  x_ready <= 1'b0;
                  busy    <= 1'b1;
                  state   <= S_MAC;
               end else begin
                  x_ready <= 1'b1;
               end
            end
            S_MAC: begin
               acc <= acc + AW'(prod);
               idx <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               y       <= sat_y;
               y_valid <= 1'b1;
               x_ready <= 1'b1;
               busy    <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               x_ready <= 1'b0;
               busy    <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_serial.sv
// Directed bench for fir_mac_serial: impulse, coefficient timing, random
// golden-model run, back-pressure, mid-operation reset and saturation.
module tb_fir_mac_serial;

   localparam int TAPS = 8;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   always #5 clk = ~clk;

   logic               coef_we = 1'b0;
   logic [2:0]         coef_addr = '0;
   logic signed [11:0] coef_data = '0;
   logic               x_valid = 1'b0;
   logic               x_ready;
   logic signed [11:0] x = '0;
   logic               y_valid;
   logic signed [31:0] y;
   logic               busy;

   logic               s_coef_we = 1'b0;
   logic [2:0]         s_coef_addr = '0;
   logic signed [11:0] s_coef_data = '0;
   logic               s_x_valid = 1'b0;
   logic               s_x_ready;
   logic signed [11:0] s_x = '0;
   logic               s_y_valid;
   logic signed [15:0] s_y;
   logic               s_busy;

   fir_mac_serial dut (
      .clk(clk), .nreset(nreset), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .x_valid(x_valid), .x_ready(x_ready), .x(x),
      .y_valid(y_valid), .y(y), .busy(busy)
   );

   fir_mac_serial #(.ACC_W(16)) dut_sat (
      .clk(clk), .nreset(nreset), .coef_we(s_coef_we), .coef_addr(s_coef_addr),
      .coef_data(s_coef_data), .x_valid(s_x_valid), .x_ready(s_x_ready), .x(s_x),
      .y_valid(s_y_valid), .y(s_y), .busy(s_busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   int mc [TAPS];
   int mh [TAPS];

   function automatic int model_push(input int xv);
      int s;
      for (int k = TAPS-1; k > 0; k--) mh[k] = mh[k-1];
      mh[0] = xv;
      s = 0;
      for (int k = 0; k < TAPS; k++) s += mc[k] * mh[k];
      return s;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < TAPS; k++) begin
         mc[k] = 0;
         mh[k] = 0;
      end
   endtask

   int yq[$];
   int yv_cnt = 0;
   always @(negedge clk) begin
      if (y_valid) begin
         yq.push_back(int'(y));
         yv_cnt++;
      end
   end

   task automatic wr_coef(input int a, input int v);
      @(negedge clk);
      coef_we = 1'b1;
      coef_addr = 3'(a);
      coef_data = 12'(v);
      @(negedge clk);
      coef_we = 1'b0;
      mc[a] = v;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!x_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, int'(x_ready), 1);
   endtask

   task automatic wait_y(input string tag, output int lat);
      lat = 0;
      while (!y_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_y_valid"}, int'(y_valid), 1);
   endtask

   task automatic send(input int xv, output int yv, output int lat);
      @(negedge clk);
      wait_ready("send");
      x = 12'(xv);
      x_valid = 1'b1;
      @(negedge clk);
      x_valid = 1'b0;
      chk("busy_in_mac", int'(busy), 1);
      chk("ready_in_mac", int'(x_ready), 0);
      wait_y("send", lat);
      yv = int'(y);
   endtask

   task automatic s_send(input int xv, output int yv);
      int n = 0;
      @(negedge clk);
      while (!s_x_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("sat_ready", int'(s_x_ready), 1);
      s_x = 12'(xv);
      s_x_valid = 1'b1;
      @(negedge clk);
      s_x_valid = 1'b0;
      n = 0;
      while (!s_y_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("sat_y_valid", int'(s_y_valid), 1);
      yv = int'(s_y);
   endtask

   initial begin
      #200000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int yv, lat, t, n, cnt0;
      int imp_exp [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
      int bp_x [5] = '{3, -7, 100, -2048, 2047};
      int at [5];
      int bp_exp[$];
      int sat_exp_hi [8] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
      int sat_exp_lo [8] = '{32767, 32767, 32767, 8192, -32768, -32768, -32768, -32768};

      model_clear();

      // reset state
      #12;
      chk("rst_x_ready", int'(x_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_y_valid", int'(y_valid), 0);
      @(negedge clk);
      nreset = 1'b1;
      #1;
      chk("ready_before_edge", int'(x_ready), 0);
      @(negedge clk);
      chk("ready_after_edge", int'(x_ready), 1);

      // impulse response with c[k] = k+1
      for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
      for (int i = 0; i < 9; i++) begin
         send((i == 0) ? 1 : 0, yv, lat);
         void'(model_push((i == 0) ? 1 : 0));
         chk("imp_y", yv, imp_exp[i]);
         chk("imp_latency", lat, 9);
         @(negedge clk);
         chk("y_valid_one_cycle", int'(y_valid), 0);
      end

      // coefficient write during MAC is ignored
      @(negedge clk);
      wait_ready("cw");
      x = 12'(5);
      x_valid = 1'b1;
      @(negedge clk);
      x_valid = 1'b0;
      coef_we = 1'b1;
      coef_addr = 3'd0;
      coef_data = 12'(100);
      @(negedge clk);
      coef_we = 1'b0;
      wait_y("cw", lat);
      chk("cw_in_mac_y", int'(y), 5);
      void'(model_push(5));

      // same write in IDLE applies to the next sample
      wr_coef(0, 100);
      send(2, yv, lat);
      void'(model_push(2));
      chk("cw_in_idle_y", yv, 210);

      // write and accept on the same edge
      @(negedge clk);
      wait_ready("same");
      coef_we = 1'b1;
      coef_addr = 3'd1;
      coef_data = 12'(-3);
      x = 12'(1);
      x_valid = 1'b1;
      @(negedge clk);
      coef_we = 1'b0;
      x_valid = 1'b0;
      mc[1] = -3;
      void'(model_push(1));
      wait_y("same", lat);
      chk("same_edge_y", int'(y), 109);
      chk("same_edge_latency", lat, 9);

      // random samples against the golden model
      for (int i = 0; i < 200; i++) begin
         int xv, ex;
         if (i == 0 || i == 100) begin
            for (int k = 0; k < TAPS; k++) wr_coef(k, int'($urandom_range(0, 4095)) - 2048);
         end
         xv = int'($urandom_range(0, 4095)) - 2048;
         ex = model_push(xv);
         send(xv, yv, lat);
         chk("rand_y", yv, ex);
      end

      // back-pressure: x_valid held across five samples
      @(negedge clk);
      wait_ready("bp");
      yq.delete();
      t = 0;
      for (int s = 0; s < 5; s++) begin
         n = 0;
         while (!x_ready && n < 40) begin
            @(negedge clk);
            t++;
            n++;
         end
         chk("bp_ready", int'(x_ready), 1);
         x = 12'(bp_x[s]);
         x_valid = 1'b1;
         bp_exp.push_back(model_push(bp_x[s]));
         at[s] = t;
         @(negedge clk);
         t++;
         chk("bp_ready_low", int'(x_ready), 0);
      end
      x_valid = 1'b0;
      for (int s = 1; s < 5; s++) chk("bp_spacing", at[s] - at[s-1], 10);
      repeat (15) @(negedge clk);
      chk("bp_count", yq.size(), 5);
      for (int s = 0; s < 5; s++) begin
         chk("bp_y", (s < yq.size()) ? yq[s] : 32'h7fff_ffff, bp_exp[s]);
      end

      // reset during the third MAC cycle
      @(negedge clk);
      wait_ready("mr");
      x = 12'(9);
      x_valid = 1'b1;
      @(negedge clk);
      x_valid = 1'b0;
      repeat (2) @(negedge clk);
      cnt0 = yv_cnt;
      #1;
      nreset = 1'b0;
      #1;
      chk("mr_y_valid", int'(y_valid), 0);
      chk("mr_y", int'(y), 0);
      chk("mr_x_ready", int'(x_ready), 0);
      chk("mr_busy", int'(busy), 0);
      @(negedge clk);
      @(negedge clk);
      nreset = 1'b1;
      #1;
      chk("mr_ready_before_edge", int'(x_ready), 0);
      @(negedge clk);
      chk("mr_ready_after_edge", int'(x_ready), 1);
      repeat (15) @(negedge clk);
      chk("mr_no_y_valid", yv_cnt, cnt0);
      model_clear();
      send(7, yv, lat);
      chk("mr_coef_zero_y", yv, 0);
      for (int k = 0; k < TAPS; k++) wr_coef(k, 1);
      send(4, yv, lat);
      chk("mr_delay_cleared_y", yv, 11);

      // saturation with ACC_W = 16
      for (int k = 0; k < TAPS; k++) begin
         @(negedge clk);
         s_coef_we = 1'b1;
         s_coef_addr = 3'(k);
         s_coef_data = 12'(-2048);
         @(negedge clk);
         s_coef_we = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         s_send(-2048, yv);
         chk("sat_pos", yv, sat_exp_hi[i]);
      end
      for (int i = 0; i < 8; i++) begin
         s_send(2047, yv);
         chk("sat_neg", yv, sat_exp_lo[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
